// File: rtl/adaptive_binarizer_if.sv
// Pixel-stream bundle between the recover stage and the binarizer, plus the
// binarizer's framebuffer-facing results.
interface adaptive_binarizer_if #(
  parameter int unsigned ADDR_W = 18
);
  logic [15:0]       pixel_in;
  logic [10:0]       hcount_in;
  logic [9:0]        vcount_in;
  logic              valid_in;
  logic [1:0]        mode_in;
  logic [7:0]        thresh_in;
  logic [7:0]        offset_in;

  logic              bin_out;
  logic [10:0]       hcount_out;
  logic [9:0]        vcount_out;
  logic              valid_out;
  logic              we_out;
  logic [ADDR_W-1:0] addr_out;

  modport master (
    output pixel_in, hcount_in, vcount_in, valid_in, mode_in, thresh_in, offset_in,
    input  bin_out, hcount_out, vcount_out, valid_out, we_out, addr_out
  );

  modport slave (
    input  pixel_in, hcount_in, vcount_in, valid_in, mode_in, thresh_in, offset_in,
    output bin_out, hcount_out, vcount_out, valid_out, we_out, addr_out
  );
endinterface

// File: rtl/adaptive_binarizer.sv
// RGB565 -> luma -> fixed / local-mean adaptive binarization, three-stage pipeline
// producing a cropped 1-bit framebuffer write (enable, address, data).
module adaptive_binarizer #(
  parameter int unsigned WIN    = 16,
  parameter int unsigned CROP_W = 480,
  parameter int unsigned CROP_H = 480,
  parameter int unsigned ADDR_W = 18
) (
  input logic                 clk_in,
  input logic                 rst_in,
  adaptive_binarizer_if.slave bus
);

  localparam int unsigned Log2Win = $clog2(WIN);
  localparam int unsigned SumW    = 8 + Log2Win;
  localparam int unsigned FillW   = Log2Win + 1;

  localparam logic [FillW-1:0]   WinFill = FillW'(WIN);
  localparam logic [FillW-1:0]   FillOne = FillW'(1);
  localparam logic [Log2Win-1:0] PtrOne  = Log2Win'(1);

  if ((WIN < 2) || (WIN > 64) || ((WIN & (WIN - 1)) != 0)) begin : g_win_check
    $error("WIN must be a power of two in 2..64");
  end

  typedef enum logic [1:0] {
    ModeFixed    = 2'd0,
    ModeAdaptive = 2'd1,
    ModeCeiling  = 2'd2
  } mode_e;

  // ---------------------------------------------------------------------------
  // Stage 0 (combinational): luma and frame-start config decode
  // ---------------------------------------------------------------------------
  logic [7:0]  r8, g8, b8;
  logic [10:0] y_acc;
  logic [7:0]  y0;
  logic        frame_start;
  mode_e       mode_dec;

  always_comb begin
    r8    = {bus.pixel_in[15:11], bus.pixel_in[15:13]};
    g8    = {bus.pixel_in[10:5], bus.pixel_in[10:9]};
    b8    = {bus.pixel_in[4:0], bus.pixel_in[4:2]};
    y_acc = {2'b00, r8, 1'b0} + (11'(g8) * 11'd5) + {3'b000, b8};
    y0    = 8'(y_acc >> 3);

    frame_start = bus.valid_in && (bus.hcount_in == '0) && (bus.vcount_in == '0);

    case (bus.mode_in)
      2'd1:    mode_dec = ModeAdaptive;
      2'd2:    mode_dec = ModeCeiling;
      default: mode_dec = ModeFixed;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Config latch and stage 1 registers
  // ---------------------------------------------------------------------------
  mode_e       cfg_mode_q;
  logic [7:0]  cfg_thresh_q;
  logic [7:0]  cfg_offset_q;

  logic        valid1_q;
  logic [7:0]  y1_q;
  logic [10:0] h1_q;
  logic [9:0]  v1_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cfg_mode_q   <= ModeFixed;
      cfg_thresh_q <= 8'd128;
      cfg_offset_q <= 8'd0;
    end else if (frame_start) begin
      cfg_mode_q   <= mode_dec;
      cfg_thresh_q <= bus.thresh_in;
      cfg_offset_q <= bus.offset_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid1_q <= 1'b0;
      y1_q     <= '0;
      h1_q     <= '0;
      v1_q     <= '0;
    end else begin
      valid1_q <= bus.valid_in;
      y1_q     <= y0;
      h1_q     <= bus.hcount_in;
      v1_q     <= bus.vcount_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: trailing window update and mean
  // ---------------------------------------------------------------------------
  logic [7:0]         ring_q [WIN];
  logic [SumW-1:0]    sum_q, sum_d;
  logic [Log2Win-1:0] ptr_q, ptr_d;
  logic [FillW-1:0]   fill_q, fill_d;
  logic [7:0]         first_q, first_d;
  logic               ring_we;
  logic [Log2Win-1:0] ring_idx;
  logic [7:0]         evicted;
  logic [7:0]         mean_d;

  always_comb begin
    sum_d    = sum_q;
    ptr_d    = ptr_q;
    fill_d   = fill_q;
    first_d  = first_q;
    ring_we  = 1'b0;
    ring_idx = ptr_q;
    evicted  = '0;
    if (valid1_q) begin
      ring_we = 1'b1;
      if (h1_q == '0) begin
        // Line start: window behaves as if pre-filled with this pixel.
        sum_d    = SumW'(y1_q) << Log2Win;
        ptr_d    = PtrOne;
        fill_d   = FillOne;
        first_d  = y1_q;
        ring_idx = '0;
      end else begin
        // Until the ring is full its unwritten slots stand in for first_y.
        evicted = (fill_q < WinFill) ? first_q : ring_q[ptr_q];
        sum_d   = sum_q + SumW'(y1_q) - SumW'(evicted);
        ptr_d   = ptr_q + PtrOne;
        if (fill_q < WinFill) begin
          fill_d = fill_q + FillOne;
        end
      end
    end
    mean_d = 8'(sum_d >> Log2Win);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < WIN; i++) begin
        ring_q[i] <= '0;
      end
    end else if (ring_we) begin
      ring_q[ring_idx] <= y1_q;
    end
  end

  logic        valid2_q;
  logic [7:0]  y2_q;
  logic [7:0]  mean2_q;
  logic [10:0] h2_q;
  logic [9:0]  v2_q;
  mode_e       mode2_q;
  logic [7:0]  thresh2_q;
  logic [7:0]  offset2_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sum_q     <= '0;
      ptr_q     <= '0;
      fill_q    <= '0;
      first_q   <= '0;
      valid2_q  <= 1'b0;
      y2_q      <= '0;
      mean2_q   <= '0;
      h2_q      <= '0;
      v2_q      <= '0;
      mode2_q   <= ModeFixed;
      thresh2_q <= '0;
      offset2_q <= '0;
    end else begin
      sum_q     <= sum_d;
      ptr_q     <= ptr_d;
      fill_q    <= fill_d;
      first_q   <= first_d;
      valid2_q  <= valid1_q;
      y2_q      <= y1_q;
      mean2_q   <= mean_d;
      h2_q      <= h1_q;
      v2_q      <= v1_q;
      // cfg_q already reflects this pixel's own frame-start latch, and no later one.
      mode2_q   <= cfg_mode_q;
      thresh2_q <= cfg_thresh_q;
      offset2_q <= cfg_offset_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: decision, crop and address
  // ---------------------------------------------------------------------------
  logic              fixed_hit;
  logic              adapt_hit;
  logic              bin_d;
  logic              in_crop;
  logic [31:0]       addr_full;
  logic [ADDR_W-1:0] addr_d;

  always_comb begin
    fixed_hit = (y2_q >= thresh2_q);
    adapt_hit = (({1'b0, y2_q} + {1'b0, offset2_q}) >= {1'b0, mean2_q});
    case (mode2_q)
      ModeAdaptive: bin_d = adapt_hit;
      ModeCeiling:  bin_d = adapt_hit | fixed_hit;
      default:      bin_d = fixed_hit;
    endcase
    in_crop   = (32'(h2_q) < CROP_W) && (32'(v2_q) < CROP_H);
    addr_full = 32'(h2_q) + (CROP_W * 32'(v2_q));
    addr_d    = ADDR_W'(addr_full);
  end

  logic              bin_q;
  logic [10:0]       h3_q;
  logic [9:0]        v3_q;
  logic              valid3_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bin_q    <= 1'b0;
      h3_q     <= '0;
      v3_q     <= '0;
      valid3_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
    end else begin
      bin_q    <= bin_d;
      h3_q     <= h2_q;
      v3_q     <= v2_q;
      valid3_q <= valid2_q;
      we_q     <= valid2_q && in_crop;
      addr_q   <= addr_d;
    end
  end

  assign bus.bin_out    = bin_q;
  assign bus.hcount_out = h3_q;
  assign bus.vcount_out = v3_q;
  assign bus.valid_out  = valid3_q;
  assign bus.we_out     = we_q;
  assign bus.addr_out   = addr_q;

endmodule

// File: tb/tb_adaptive_binarizer.sv
// Scoreboard bench for adaptive_binarizer: a per-line luma history model predicts
// each output; a negedge monitor pops and compares whenever valid_out is seen.
module tb_adaptive_binarizer;

  localparam int unsigned WIN    = 16;
  localparam int unsigned CROP_W = 480;
  localparam int unsigned CROP_H = 480;
  localparam int unsigned ADDR_W = 18;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  adaptive_binarizer_if #(.ADDR_W(ADDR_W)) bus ();

  adaptive_binarizer #(
    .WIN   (WIN),
    .CROP_W(CROP_W),
    .CROP_H(CROP_H),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int bin;
    int h;
    int v;
    int we;
    int addr;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   hist[$];
  int   m_mode   = 0;
  int   m_thresh = 128;
  int   m_offset = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int luma(input logic [15:0] p);
    int r, g, b;
    r = int'(p[15:11]);
    g = int'(p[10:5]);
    b = int'(p[4:0]);
    r = r * 8 + r / 4;
    g = g * 4 + g / 16;
    b = b * 8 + b / 4;
    return (2 * r + 5 * g + b) / 8;
  endfunction

  task automatic set_cfg(input int mode, input int thresh, input int offset);
    bus.mode_in   = 2'(mode);
    bus.thresh_in = 8'(thresh);
    bus.offset_in = 8'(offset);
  endtask

  // Model: window = last WIN lumas of the line, padded with the line's first pixel.
  task automatic send(input logic [15:0] pix, input int h, input int v, input int gap);
    exp_t e;
    int   y, n, sum, mean, idx;
    bit   fixed_hit, adapt_hit;
    bus.pixel_in  = pix;
    bus.hcount_in = 11'(h);
    bus.vcount_in = 10'(v);
    bus.valid_in  = 1'b1;
    y = luma(pix);
    if (h == 0 && v == 0) begin
      m_mode   = (int'(bus.mode_in) == 3) ? 0 : int'(bus.mode_in);
      m_thresh = int'(bus.thresh_in);
      m_offset = int'(bus.offset_in);
    end
    if (h == 0) hist.delete();
    hist.push_back(y);
    if (hist.size() > WIN) void'(hist.pop_front());
    n   = hist.size();
    sum = 0;
    for (int k = 0; k < WIN; k++) begin
      idx = n - WIN + k;
      sum += hist[(idx < 0) ? 0 : idx];
    end
    mean      = sum / WIN;
    fixed_hit = (y >= m_thresh);
    adapt_hit = (y + m_offset >= mean);
    e.bin  = (m_mode == 0) ? int'(fixed_hit) :
             (m_mode == 1) ? int'(adapt_hit) : int'(adapt_hit | fixed_hit);
    e.h    = h;
    e.v    = v;
    e.we   = (h < CROP_W && v < CROP_H) ? 1 : 0;
    e.addr = (h + CROP_W * v) % (1 << ADDR_W);
    e.cyc  = cyc + 3;
    exp_q.push_back(e);
    @(posedge clk_in);
    #1;
    bus.valid_in = 1'b0;
    repeat (gap) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  exp_t got;
  always @(negedge clk_in) begin
    if (!rst_in && bus.valid_out) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_valid: valid_out=1, expected no pending pixel (cycle %0d)",
                 cyc);
      end else begin
        got = exp_q.pop_front();
        check("latency_cycle", cyc, got.cyc);
        check("bin_out", int'(bus.bin_out), got.bin);
        check("hcount_out", int'(bus.hcount_out), got.h);
        check("vcount_out", int'(bus.vcount_out), got.v);
        check("we_out", int'(bus.we_out), got.we);
        if (got.we != 0) check("addr_out", int'(bus.addr_out), got.addr);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d pixels pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  function automatic int outs_nonzero();
    return int'(|{bus.bin_out, bus.hcount_out, bus.vcount_out, bus.valid_out, bus.we_out,
                  bus.addr_out});
  endfunction

  int v, h, len;

  initial begin
    bus.pixel_in  = '0;
    bus.hcount_in = '0;
    bus.vcount_in = '0;
    bus.valid_in  = 1'b0;
    set_cfg(0, 128, 0);
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_outputs_zero", outs_nonzero(), 0);
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;

    // Frame start, fixed mode, white pixel
    send(16'hFFFF, 0, 0, 2);

    // Luma / fixed threshold
    set_cfg(0, 130, 0);
    send(16'h8410, 0, 0, 0);
    send(16'h0000, 1, 0, 0);
    send(16'hFFFF, 2, 0, 1);
    set_cfg(0, 131, 0);
    send(16'h8410, 0, 0, 1);

    // Adaptive edge: 20 blacks then 21 whites
    set_cfg(1, 0, 0);
    for (int i = 0; i < 20; i++) send(16'h0000, i, 0, 0);
    for (int i = 20; i < 41; i++) send(16'hFFFF, i, 0, 0);
    // Offset 20, black after a full white window
    set_cfg(1, 0, 20);
    for (int i = 0; i < 20; i++) send(16'hFFFF, i, 0, 0);
    send(16'h0000, 20, 0, 0);
    for (int i = 21; i < 30; i++) send(16'hFFFF, i, 0, 0);
    // Line restart with black after whites
    send(16'h0000, 0, 1, 0);
    send(16'h0000, 1, 1, 1);

    // Config latch: mode_in changes mid-frame are ignored
    set_cfg(0, 128, 0);
    send(16'h8410, 0, 0, 0);
    set_cfg(1, 0, 200);
    for (int i = 1; i < 20; i++) send((i % 3 == 0) ? 16'h4208 : 16'hFFFF, i, 0, 0);

    // Mode 2 ceiling: y=130 below a near-white mean, thresh 100
    set_cfg(2, 100, 0);
    for (int i = 0; i < 16; i++) send(16'hFFFF, i, 0, 0);
    send(16'h8410, 16, 0, 0);
    set_cfg(2, 200, 0);
    send(16'h8410, 17, 0, 0);

    // Crop boundary with idle gaps
    send(16'hFFFF, 479, 479, $urandom_range(1, 5));
    send(16'hFFFF, 480, 479, $urandom_range(1, 5));
    send(16'hFFFF, 0, 480, $urandom_range(1, 5));
    send(16'h0000, 478, 479, $urandom_range(1, 5));
    send(16'hFFFF, 1, 1, $urandom_range(1, 5));

    // Reset asserted with pixels in flight
    set_cfg(1, 50, 0);
    send(16'h1234, 5, 3, 0);
    send(16'h5678, 6, 3, 0);
    rst_in = 1'b1;
    exp_q.delete();
    hist.delete();
    m_mode   = 0;
    m_thresh = 128;
    m_offset = 0;
    #1;
    check("midstream_reset_outputs_zero", outs_nonzero(), 0);
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;
    set_cfg(0, 128, 0);
    send(16'hFFFF, 0, 0, 0);
    send(16'h0000, 1, 0, 0);

    // Randomized frames: random config, mid-frame config noise, jumps and gaps
    for (int f = 0; f < 8; f++) begin
      set_cfg($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 63));
      for (int l = 0; l < 4; l++) begin
        v   = (l == 0) ? 0 : $urandom_range(1, 600);
        h   = 0;
        len = $urandom_range(4, 40);
        for (int p = 0; p < len; p++) begin
          send(16'($urandom), h, v, $urandom_range(0, 2));
          set_cfg($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255));
          if ($urandom_range(0, 7) == 0) h = h + $urandom_range(2, 300);
          else h = h + 1;
          if (h > 2047) h = $urandom_range(1, 2047);
        end
      end
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk_in);
    @(negedge clk_in);
    check("drain_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
